// File: rtl/axi_lite_spi_stream_master.sv
// AXI4-Lite master driving an SPI peripheral from a byte stream.
// Per byte: write TX, poll BUSY until clear, read RX, emit received byte.
module axi_lite_spi_stream_master #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    POLL_LIMIT = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [7:0]              s_tx_data,
    input  logic                    s_tx_valid,
    output logic                    s_tx_ready,
    output logic [7:0]              m_rx_data,
    output logic                    m_rx_valid,
    input  logic                    m_rx_ready,
    output logic                    busy,
    output logic                    err_sticky,
    output logic [1:0]              err_code,
    input  logic                    err_clear,
    output logic [ADDR_WIDTH-1:0]   M_AXI_awaddr,
    output logic [2:0]              M_AXI_awprot,
    output logic                    M_AXI_awvalid,
    input  logic                    M_AXI_awready,
    output logic [DATA_WIDTH-1:0]   M_AXI_wdata,
    output logic [3:0]              M_AXI_wstrb,
    output logic                    M_AXI_wvalid,
    input  logic                    M_AXI_wready,
    input  logic [1:0]              M_AXI_bresp,
    input  logic                    M_AXI_bvalid,
    output logic                    M_AXI_bready,
    output logic [ADDR_WIDTH-1:0]   M_AXI_araddr,
    output logic [2:0]              M_AXI_arprot,
    output logic                    M_AXI_arvalid,
    input  logic                    M_AXI_arready,
    input  logic [DATA_WIDTH-1:0]   M_AXI_rdata,
    input  logic [1:0]              M_AXI_rresp,
    input  logic                    M_AXI_rvalid,
    output logic                    M_AXI_rready
);

    typedef enum logic [2:0] {
        IDLE, WR, WR_B, POLL_AR, POLL_R, RX_AR, RX_R
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] A_TX   = BASE_ADDR;
    localparam logic [ADDR_WIDTH-1:0] A_RX   = BASE_ADDR + ADDR_WIDTH'(8);
    localparam logic [ADDR_WIDTH-1:0] A_BUSY = BASE_ADDR + ADDR_WIDTH'(12);
    localparam logic [7:0]            LIMIT  = 8'(POLL_LIMIT);
    localparam logic [1:0]            E_WR   = 2'b01;
    localparam logic [1:0]            E_RD   = 2'b10;
    localparam logic [1:0]            E_TO   = 2'b11;

    state_t                  r_state;
    logic [7:0]              r_poll_cnt;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [3:0]              r_wstrb;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_bready;
    logic                    r_arvalid;
    logic                    r_rready;
    logic [7:0]              r_rx_data;
    logic                    r_rx_valid;
    logic                    r_err_sticky;
    logic [1:0]              r_err_code;

    logic       w_aw_done;
    logic       w_w_done;
    logic       w_resp_err;
    logic [7:0] w_poll_next;
    logic       w_unused;

    assign w_aw_done   = !r_awvalid || M_AXI_awready;
    assign w_w_done    = !r_wvalid || M_AXI_wready;
    assign w_resp_err  = M_AXI_rresp != 2'b00;
    assign w_poll_next = r_poll_cnt + 8'd1;
    assign w_unused    = ^M_AXI_rdata[DATA_WIDTH-1:8];

    assign s_tx_ready    = (r_state == IDLE) && !r_rx_valid;
    assign busy          = r_state != IDLE;
    assign m_rx_data     = r_rx_data;
    assign m_rx_valid    = r_rx_valid;
    assign err_sticky    = r_err_sticky;
    assign err_code      = r_err_code;
    assign M_AXI_awaddr  = r_awaddr;
    assign M_AXI_awprot  = 3'b000;
    assign M_AXI_awvalid = r_awvalid;
    assign M_AXI_wdata   = r_wdata;
    assign M_AXI_wstrb   = r_wstrb;
    assign M_AXI_wvalid  = r_wvalid;
    assign M_AXI_bready  = r_bready;
    assign M_AXI_araddr  = r_araddr;
    assign M_AXI_arprot  = 3'b000;
    assign M_AXI_arvalid = r_arvalid;
    assign M_AXI_rready  = r_rready;

    // Transaction sequencer: all AXI and stream outputs are registered here.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state      <= IDLE;
            r_poll_cnt   <= '0;
            r_awaddr     <= '0;
            r_araddr     <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_code   <= '0;
        end else begin
            // Clear first so an error raised below in the same cycle wins.
            if (err_clear) begin
                r_err_sticky <= 1'b0;
                r_err_code   <= '0;
            end
            if (r_rx_valid && m_rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (s_tx_valid && s_tx_ready) begin
                        r_awaddr  <= A_TX;
                        r_wdata   <= {{(DATA_WIDTH-8){1'b0}}, s_tx_data};
                        r_wstrb   <= 4'b0001;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= WR;
                    end
                end
                WR: begin
                    if (M_AXI_awready) r_awvalid <= 1'b0;
                    if (M_AXI_wready)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_B;
                    end
                end
                WR_B: begin
                    if (M_AXI_bvalid) begin
                        r_bready <= 1'b0;
                        if (M_AXI_bresp != 2'b00) begin
                            r_err_sticky <= 1'b1;
                            r_err_code   <= E_WR;
                            r_state      <= IDLE;
                        end else begin
                            r_poll_cnt <= '0;
                            r_araddr   <= A_BUSY;
                            r_arvalid  <= 1'b1;
                            r_state    <= POLL_AR;
                        end
                    end
                end
                POLL_AR: begin
                    if (M_AXI_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= POLL_R;
                    end
                end
                POLL_R: begin
                    if (M_AXI_rvalid) begin
                        r_rready <= 1'b0;
                        if (w_resp_err) begin
                            r_err_sticky <= 1'b1;
                            r_err_code   <= E_RD;
                            r_state      <= IDLE;
                        end else if (!M_AXI_rdata[0]) begin
                            r_araddr  <= A_RX;
                            r_arvalid <= 1'b1;
                            r_state   <= RX_AR;
                        end else begin
                            r_poll_cnt <= w_poll_next;
                            if (w_poll_next == LIMIT) begin
                                r_err_sticky <= 1'b1;
                                r_err_code   <= E_TO;
                                r_state      <= IDLE;
                            end else begin
                                r_arvalid <= 1'b1;
                                r_state   <= POLL_AR;
                            end
                        end
                    end
                end
                RX_AR: begin
                    if (M_AXI_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RX_R;
                    end
                end
                RX_R: begin
                    if (M_AXI_rvalid) begin
                        r_rready <= 1'b0;
                        r_state  <= IDLE;
                        if (w_resp_err) begin
                            r_err_sticky <= 1'b1;
                            r_err_code   <= E_RD;
                        end else begin
                            r_rx_data  <= M_AXI_rdata[7:0];
                            r_rx_valid <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_spi_stream_master.sv
// Scoreboard bench for axi_lite_spi_stream_master.
// A slave model answers AXI traffic; a monitor checks observed events in order.
module tb_axi_lite_spi_stream_master;

    localparam int EV_AW = 1;
    localparam int EV_W  = 2;
    localparam int EV_AR = 3;
    localparam int EV_RX = 4;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [7:0]  s_tx_data = '0;
    logic        s_tx_valid = 1'b0;
    logic        s_tx_ready;
    logic [7:0]  m_rx_data;
    logic        m_rx_valid;
    logic        m_rx_ready = 1'b1;
    logic        busy;
    logic        err_sticky;
    logic [1:0]  err_code;
    logic        err_clear = 1'b0;
    logic [31:0] M_AXI_awaddr;
    logic [2:0]  M_AXI_awprot;
    logic        M_AXI_awvalid;
    logic        M_AXI_awready;
    logic [31:0] M_AXI_wdata;
    logic [3:0]  M_AXI_wstrb;
    logic        M_AXI_wvalid;
    logic        M_AXI_wready;
    logic [1:0]  M_AXI_bresp;
    logic        M_AXI_bvalid;
    logic        M_AXI_bready;
    logic [31:0] M_AXI_araddr;
    logic [2:0]  M_AXI_arprot;
    logic        M_AXI_arvalid;
    logic        M_AXI_arready;
    logic [31:0] M_AXI_rdata;
    logic [1:0]  M_AXI_rresp;
    logic        M_AXI_rvalid;
    logic        M_AXI_rready;

    int          errors = 0;
    int          checks = 0;
    ev_t         exp_q[$];

    int          cfg_busy_n = 0;
    int          cfg_aw_delay = 0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [1:0]  cfg_rresp_rx = 2'b00;
    logic [31:0] cfg_rx = 32'h0;

    int          aw_cnt;
    logic        aw_got;
    logic        w_got;
    int          poll_idx;

    int          n_awv = 0;
    int          n_wv = 0;
    int          n_b = 0;
    logic        prev_awv = 1'b0;
    logic [31:0] prev_awaddr = '0;

    axi_lite_spi_stream_master dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s_tx_data(s_tx_data), .s_tx_valid(s_tx_valid),
        .s_tx_ready(s_tx_ready),
        .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid),
        .m_rx_ready(m_rx_ready),
        .busy(busy), .err_sticky(err_sticky), .err_code(err_code),
        .err_clear(err_clear),
        .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awprot(M_AXI_awprot),
        .M_AXI_awvalid(M_AXI_awvalid), .M_AXI_awready(M_AXI_awready),
        .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb),
        .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready),
        .M_AXI_bresp(M_AXI_bresp), .M_AXI_bvalid(M_AXI_bvalid),
        .M_AXI_bready(M_AXI_bready),
        .M_AXI_araddr(M_AXI_araddr), .M_AXI_arprot(M_AXI_arprot),
        .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready),
        .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp),
        .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready)
    );

    always #5 ACLK = ~ACLK;

    // Slave ready signals: W always ready, AW after a configurable wait.
    assign M_AXI_wready  = 1'b1;
    assign M_AXI_arready = 1'b1;
    assign M_AXI_awready = M_AXI_awvalid && (aw_cnt >= cfg_aw_delay);

    // Slave write side: one B after both AW and W have been taken.
    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_cnt       <= 0;
            aw_got       <= 1'b0;
            w_got        <= 1'b0;
            M_AXI_bvalid <= 1'b0;
            M_AXI_bresp  <= 2'b00;
        end else begin
            if (M_AXI_bvalid && M_AXI_bready) M_AXI_bvalid <= 1'b0;
            if (M_AXI_awvalid && !M_AXI_awready) aw_cnt <= aw_cnt + 1;
            if (M_AXI_awvalid && M_AXI_awready) begin
                aw_cnt <= 0;
                aw_got <= 1'b1;
            end
            if (M_AXI_wvalid && M_AXI_wready) w_got <= 1'b1;
            if ((aw_got || (M_AXI_awvalid && M_AXI_awready)) &&
                (w_got || (M_AXI_wvalid && M_AXI_wready)) &&
                !M_AXI_bvalid) begin
                M_AXI_bvalid <= 1'b1;
                M_AXI_bresp  <= cfg_bresp;
                aw_got       <= 1'b0;
                w_got        <= 1'b0;
            end
        end
    end

    // Slave read side: BUSY reads 1 for cfg_busy_n polls, RX returns cfg_rx.
    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            M_AXI_rvalid <= 1'b0;
            M_AXI_rdata  <= '0;
            M_AXI_rresp  <= 2'b00;
            poll_idx     <= 0;
        end else begin
            if (M_AXI_rvalid && M_AXI_rready) M_AXI_rvalid <= 1'b0;
            if (M_AXI_awvalid && M_AXI_awready) poll_idx <= 0;
            if (M_AXI_arvalid && M_AXI_arready) begin
                M_AXI_rvalid <= 1'b1;
                if (M_AXI_araddr == 32'hC) begin
                    M_AXI_rdata <= (poll_idx < cfg_busy_n) ? 32'h1 : 32'h0;
                    M_AXI_rresp <= 2'b00;
                    poll_idx    <= poll_idx + 1;
                end else begin
                    M_AXI_rdata <= cfg_rx;
                    M_AXI_rresp <= cfg_rresp_rx;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input string name, input int kind,
                          input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected event a=%h d=%h expected none",
                     name, a, d);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_kind"}, 32'(kind), 32'(e.kind));
            chk({name, "_addr"}, a, e.a);
            chk({name, "_data"}, d, e.d);
        end
    endtask

    // Monitor: handshakes seen at the negedge complete on the next posedge.
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (M_AXI_awvalid && M_AXI_awready)
                sb_pop("aw", EV_AW, M_AXI_awaddr, 32'h0);
            if (M_AXI_wvalid && M_AXI_wready)
                sb_pop("w", EV_W, {28'h0, M_AXI_wstrb}, M_AXI_wdata);
            if (M_AXI_arvalid && M_AXI_arready)
                sb_pop("ar", EV_AR, M_AXI_araddr, 32'h0);
            if (m_rx_valid && m_rx_ready)
                sb_pop("rx", EV_RX, 32'h0, {24'h0, m_rx_data});
            if (M_AXI_awvalid && prev_awv)
                chk("aw_stable", M_AXI_awaddr, prev_awaddr);
            if (M_AXI_awvalid || M_AXI_arvalid)
                chk("prot", {26'h0, M_AXI_awprot, M_AXI_arprot}, 32'h0);
            if (M_AXI_awvalid) n_awv++;
            if (M_AXI_wvalid) n_wv++;
            if (M_AXI_bvalid && M_AXI_bready) n_b++;
            prev_awv    = M_AXI_awvalid;
            prev_awaddr = M_AXI_awaddr;
        end else begin
            prev_awv = 1'b0;
        end
    end

    task automatic push(input int kind, input logic [31:0] a,
                        input logic [31:0] d);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        exp_q.push_back(e);
    endtask

    task automatic push_write(input logic [7:0] b);
        push(EV_AW, 32'h0, 32'h0);
        push(EV_W, 32'h1, {24'h0, b});
    endtask

    task automatic send(input logic [7:0] b);
        logic rdy;
        int   t;
        @(posedge ACLK);
        #1;
        s_tx_data  = b;
        s_tx_valid = 1'b1;
        t = 0;
        do begin
            rdy = s_tx_ready;
            @(posedge ACLK);
            t++;
        end while (!rdy && t < 100);
        #1;
        s_tx_valid = 1'b0;
        if (!rdy) chk("tx_handshake_timeout", 32'h0, 32'h1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (busy && lat < 200) begin
            @(posedge ACLK);
            #1;
            lat++;
        end
        if (busy) chk("done_timeout", 32'h1, 32'h0);
    endtask

    task automatic settle();
        repeat (3) @(posedge ACLK);
        #1;
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic pulse_clear();
        @(posedge ACLK);
        #1;
        err_clear = 1'b1;
        @(posedge ACLK);
        #1;
        err_clear = 1'b0;
    endtask

    initial begin
        int lat;
        int s_awv, s_wv, s_b;

        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_tx_ready", 32'(s_tx_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", {30'h0, err_code} | 32'(err_sticky), 32'h0);
        chk("rst_valids", {27'h0, M_AXI_awvalid, M_AXI_wvalid,
            M_AXI_arvalid, M_AXI_bready, M_AXI_rready}, 32'h0);
        chk("rst_rx", {23'h0, m_rx_valid, m_rx_data}, 32'h0);
        chk("rst_wstrb", {28'h0, M_AXI_wstrb}, 32'h0);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        chk("idle_tx_ready", 32'(s_tx_ready), 32'h1);

        // Single byte, zero-wait slave, BUSY clear on first read.
        cfg_rx = 32'h0000_00A5;
        push_write(8'h3C);
        push(EV_AR, 32'hC, 32'h0);
        push(EV_AR, 32'h8, 32'h0);
        push(EV_RX, 32'h0, 32'hA5);
        send(8'h3C);
        wait_done(lat);
        chk("t1_latency", 32'(lat), 32'd6);
        chk("t1_rx_valid", 32'(m_rx_valid), 32'h1);
        chk("t1_err", 32'(err_sticky), 32'h0);
        settle();

        // BUSY set for three polls.
        cfg_busy_n = 3;
        cfg_rx     = 32'h0000_005A;
        push_write(8'h11);
        repeat (4) push(EV_AR, 32'hC, 32'h0);
        push(EV_AR, 32'h8, 32'h0);
        push(EV_RX, 32'h0, 32'h5A);
        send(8'h11);
        wait_done(lat);
        chk("t2_latency", 32'(lat), 32'd12);
        chk("t2_err", 32'(err_sticky), 32'h0);
        settle();

        // BUSY stuck: timeout after exactly POLL_LIMIT reads.
        cfg_busy_n = 1000;
        push_write(8'h22);
        repeat (16) push(EV_AR, 32'hC, 32'h0);
        send(8'h22);
        wait_done(lat);
        chk("t3_rx_valid", 32'(m_rx_valid), 32'h0);
        chk("t3_sticky", 32'(err_sticky), 32'h1);
        chk("t3_code", {30'h0, err_code}, 32'h3);
        settle();
        pulse_clear();
        chk("t3_clr_sticky", 32'(err_sticky), 32'h0);
        chk("t3_clr_code", {30'h0, err_code}, 32'h0);
        cfg_busy_n = 0;

        // Write response error: no reads, ready again immediately.
        cfg_bresp = 2'b10;
        push_write(8'h33);
        send(8'h33);
        wait_done(lat);
        chk("t4_code", {30'h0, err_code}, 32'h1);
        chk("t4_sticky", 32'(err_sticky), 32'h1);
        chk("t4_tx_ready", 32'(s_tx_ready), 32'h1);
        settle();
        cfg_bresp = 2'b00;

        // Read response error on RX read: no output byte.
        cfg_rresp_rx = 2'b10;
        push_write(8'h44);
        push(EV_AR, 32'hC, 32'h0);
        push(EV_AR, 32'h8, 32'h0);
        send(8'h44);
        wait_done(lat);
        chk("t4r_code", {30'h0, err_code}, 32'h2);
        chk("t4r_rx_valid", 32'(m_rx_valid), 32'h0);
        settle();
        cfg_rresp_rx = 2'b00;
        pulse_clear();
        chk("t4r_clr", {29'h0, err_sticky, err_code}, 32'h0);

        // Delayed awready, then output backpressure.
        cfg_aw_delay = 3;
        cfg_rx       = 32'h0000_0077;
        m_rx_ready   = 1'b0;
        push(EV_W, 32'h1, 32'h55);
        push(EV_AW, 32'h0, 32'h0);
        push(EV_AR, 32'hC, 32'h0);
        push(EV_AR, 32'h8, 32'h0);
        push(EV_RX, 32'h0, 32'h77);
        s_awv = n_awv;
        s_wv  = n_wv;
        s_b   = n_b;
        send(8'h55);
        wait_done(lat);
        chk("t5_awv_cycles", 32'(n_awv - s_awv), 32'd4);
        chk("t5_wv_cycles", 32'(n_wv - s_wv), 32'd1);
        chk("t5_b_count", 32'(n_b - s_b), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid", 32'(m_rx_valid), 32'h1);
            chk("t5_hold_data", {24'h0, m_rx_data}, 32'h77);
            chk("t5_hold_tx_ready", 32'(s_tx_ready), 32'h0);
            @(posedge ACLK);
            #1;
        end
        m_rx_ready = 1'b1;
        @(posedge ACLK);
        #1;
        chk("t5_rx_cleared", 32'(m_rx_valid), 32'h0);
        chk("t5_tx_ready", 32'(s_tx_ready), 32'h1);
        settle();
        cfg_aw_delay = 0;

        // Reset asserted while waiting for the BUSY read data.
        cfg_busy_n = 1000;
        push_write(8'h66);
        push(EV_AR, 32'hC, 32'h0);
        send(8'h66);
        lat = 0;
        while (!M_AXI_rready && lat < 50) begin
            @(posedge ACLK);
            #1;
            lat++;
        end
        chk("t6_in_poll_r", 32'(M_AXI_rready), 32'h1);
        #1;
        ARESETN = 1'b0;
        #1;
        chk("t6_async_valids", {27'h0, M_AXI_awvalid, M_AXI_wvalid,
            M_AXI_arvalid, M_AXI_bready, M_AXI_rready}, 32'h0);
        chk("t6_async_busy", 32'(busy), 32'h0);
        chk("t6_async_rx", 32'(m_rx_valid), 32'h0);
        cfg_busy_n = 0;
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        chk("t6_tx_ready", 32'(s_tx_ready), 32'h1);
        chk("t6_err", {29'h0, err_sticky, err_code}, 32'h0);
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
